// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Purpose  : Time-division demultiplexer. One word arrives per slot, and
//            slot 0 is marked by frame_sync. Each word goes to one of NUM_CH
//            registered channel outputs, and a one-cycle strobe marks the
//            channel that was written. A hunt/lock state machine tracks frame
//            alignment and pulses sync_err when alignment is violated.
// Option   : TDM_DEMUX_CLR_ON_DISABLE_EN - when defined, dout is cleared on
//            every cycle in which enable is low. When not defined, dout holds.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   input  logic                     frame_sync,
   output logic [NUM_CH*DATA_W-1:0] dout,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic                     frame_done,
   output logic                     locked,
   output logic                     sync_err,
   output logic [SLOT_W-1:0]        slot
);

   // Slot index of the last channel in a frame; a write here ends the frame.
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
   localparam logic [NUM_CH-1:0] STROBE0   = {{(NUM_CH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] ch_reg [NUM_CH];

   // A word only counts when the demux is enabled and the word is valid.
   logic accept;
   assign accept = enable & din_valid;

   // Alignment FSM, channel registers, strobes and slot counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_HUNT;
         locked     <= 1'b0;
         slot       <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            ch_reg[k] <= '0;
         end
      end else begin
         // The strobes are single-cycle pulses. They drop to 0 unless a
         // branch below raises one of them again.
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;

         if (accept) begin
            unique case (state)
               ST_HUNT: begin
                  // While searching for alignment, words that do not carry
                  // frame_sync are dropped silently.
                  if (frame_sync) begin
                     ch_reg[0] <= din;
                     ch_valid  <= STROBE0;
                     slot      <= SLOT_ONE;
                     state     <= ST_LOCK;
                     locked    <= 1'b1;
                  end
               end

               ST_LOCK: begin
                  if (frame_sync) begin
                     // frame_sync always starts a new frame at slot 0. An
                     // early sync truncates the current frame, so no
                     // frame_done is raised for it.
                     if (slot != '0) begin
                        sync_err <= 1'b1;
                     end
                     ch_reg[0] <= din;
                     ch_valid  <= STROBE0;
                     slot      <= SLOT_ONE;
                  end else if (slot == '0) begin
                     // Slot 0 was expected but frame_sync is missing, so
                     // alignment is lost. Drop the word and start hunting.
                     sync_err <= 1'b1;
                     state    <= ST_HUNT;
                     locked   <= 1'b0;
                     slot     <= '0;
                  end else begin
                     ch_reg[slot] <= din;
                     ch_valid     <= STROBE0 << slot;
                     if (slot == LAST_SLOT) begin
                        slot       <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        slot <= slot + SLOT_ONE;
                     end
                  end
               end

               default: begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
                  slot   <= '0;
               end
            endcase
         end else if (!enable) begin
`ifdef TDM_DEMUX_CLR_ON_DISABLE_EN
            // While disabled, force the channel outputs to zero. This
            // matches the zero output of the enabled multiplexer.
            for (int k = 0; k < NUM_CH; k++) begin
               ch_reg[k] <= '0;
            end
`endif
         end
      end
   end

   // Pack the channel registers onto the flat output bus. Channel k goes to
   // bits [k*DATA_W +: DATA_W].
   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
         assign dout[g*DATA_W +: DATA_W] = ch_reg[g];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : Self-checking bench for tdm_demux. It runs directed scenarios
//            with literal expectations, then a randomized stream. A
//            frame-level reference model is compared against the DUT on
//            every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int SLOT_W = $clog2(NUM_CH);
   localparam int DW     = NUM_CH * DATA_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              frame_sync;
   logic [DW-1:0]     dout;
   logic [NUM_CH-1:0] ch_valid;
   logic              frame_done;
   logic              locked;
   logic              sync_err;
   logic [SLOT_W-1:0] slot;

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .din(din),
      .din_valid(din_valid), .frame_sync(frame_sync), .dout(dout),
      .ch_valid(ch_valid), .frame_done(frame_done), .locked(locked),
      .sync_err(sync_err), .slot(slot)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // The model keeps each channel's word, an aligned flag and the expected
   // slot position within the frame. It also holds the strobes that should
   // be visible after the current edge.
   int unsigned m_ch [NUM_CH];
   bit          m_aligned;
   int          m_pos;
   int unsigned e_cv;
   bit          e_fd, e_se;

   always @(posedge clk) begin
      e_cv = 0; e_fd = 0; e_se = 0;
      if (!rst_n) begin
         foreach (m_ch[k]) m_ch[k] = 0;
         m_aligned = 0;
         m_pos     = 0;
      end else if (enable && din_valid) begin
         if (frame_sync) begin
            // A frame_sync word is always slot 0. It is a sync error only
            // when the model was aligned and expected some other slot.
            if (m_aligned && m_pos != 0) e_se = 1;
            m_ch[0]   = din;
            e_cv      = 1;
            m_aligned = 1;
            m_pos     = 1 % NUM_CH;
         end else if (m_aligned) begin
            if (m_pos == 0) begin
               e_se      = 1;
               m_aligned = 0;
            end else begin
               m_ch[m_pos] = din;
               e_cv        = 1 << m_pos;
               e_fd        = (m_pos == NUM_CH - 1);
               m_pos       = (m_pos + 1) % NUM_CH;
            end
         end
      end else if (!enable) begin
`ifdef TDM_DEMUX_CLR_ON_DISABLE_EN
         foreach (m_ch[k]) m_ch[k] = 0;
`endif
      end
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_dout();
      logic [DW-1:0] v = '0;
      for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = DATA_W'(m_ch[k]);
      return v;
   endfunction

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("m_dout", 64'(dout), 64'(model_dout()));
         check("m_ch_valid", 64'(ch_valid), 64'(e_cv));
         check("m_frame_done", 64'(frame_done), 64'(e_fd));
         check("m_sync_err", 64'(sync_err), 64'(e_se));
         check("m_locked", 64'(locked), 64'(m_aligned));
         check("m_slot", 64'(slot), 64'(m_aligned ? m_pos : 0));
         check("onehot_cv", 64'($countones(ch_valid) <= 1), 64'(1));
         check("fd_se_excl", 64'(frame_done & sync_err), 64'(0));
      end
   end

   // ---------------- stimulus helpers ----------------
   // Each call applies one cycle of inputs and returns #1 after the edge,
   // so the registered results of that cycle are already visible.
   task automatic step(input bit en, input bit v, input bit fs,
                       input logic [DATA_W-1:0] d);
      enable = en; din_valid = v; frame_sync = fs; din = d;
      @(posedge clk); #1;
   endtask

   task automatic word(input bit fs, input logic [DATA_W-1:0] d);
      step(1'b1, 1'b1, fs, d);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
   endtask

   logic [DW-1:0] saved;
   int            sent;

   initial begin
      rst_n = 1'b0; enable = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
      din = '0;
      @(posedge clk); #1;
      cmp_on = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_dout", 64'(dout), 64'h0);
      check("rst_locked", 64'(locked), 64'h0);
      check("rst_slot", 64'(slot), 64'h0);

      // Reset then lock: one full frame.
      word(1'b1, 8'h11); check("lk_cv0", 64'(ch_valid), 64'h1);
      check("lk_locked", 64'(locked), 64'h1);
      word(1'b0, 8'h22); check("lk_cv1", 64'(ch_valid), 64'h2);
      word(1'b0, 8'h33); check("lk_cv2", 64'(ch_valid), 64'h4);
      check("lk_fd_early", 64'(frame_done), 64'h0);
      word(1'b0, 8'h44); check("lk_cv3", 64'(ch_valid), 64'h8);
      check("lk_fd", 64'(frame_done), 64'h1);
      check("lk_dout", 64'(dout), 64'h44332211);
      check("lk_slot", 64'(slot), 64'h0);
      check("lk_se", 64'(sync_err), 64'h0);

      // Hunt discard.
      pulse_reset();
      word(1'b0, 8'hAA); check("hd_cv_a", 64'(ch_valid), 64'h0);
      word(1'b0, 8'hBB); check("hd_cv_b", 64'(ch_valid), 64'h0);
      check("hd_unlocked", 64'(locked), 64'h0);
      word(1'b1, 8'hCC); check("hd_cv_c", 64'(ch_valid), 64'h1);
      check("hd_ch0", 64'(dout[7:0]), 64'hCC);
      check("hd_locked", 64'(locked), 64'h1);

      // Gaps and disable, starting at slot 2.
      word(1'b0, 8'h12); check("gd_slot2", 64'(slot), 64'h2);
      saved = dout;
      repeat (3) idle();
      check("gd_gap_slot", 64'(slot), 64'h2);
      check("gd_gap_dout", 64'(dout), 64'(saved));
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h77);
         check("gd_dis_cv", 64'(ch_valid), 64'h0);
`ifdef TDM_DEMUX_CLR_ON_DISABLE_EN
         check("gd_dis_dout", 64'(dout), 64'h0);
`else
         check("gd_dis_dout", 64'(dout), 64'(saved));
`endif
         check("gd_dis_slot", 64'(slot), 64'h2);
      end
      word(1'b0, 8'h55); check("gd_cv2", 64'(ch_valid), 64'h4);
      check("gd_ch2", 64'(dout[23:16]), 64'h55);

      // Early sync: finish the frame, then move to slot 2.
      word(1'b0, 8'h01); check("es_fd", 64'(frame_done), 64'h1);
      word(1'b1, 8'hA0);
      word(1'b0, 8'hA1); check("es_slot2", 64'(slot), 64'h2);
      word(1'b1, 8'h99);
      check("es_se", 64'(sync_err), 64'h1);
      check("es_cv", 64'(ch_valid), 64'h1);
      check("es_ch0", 64'(dout[7:0]), 64'h99);
      check("es_slot", 64'(slot), 64'h1);
      check("es_locked", 64'(locked), 64'h1);
      check("es_fd", 64'(frame_done), 64'h0);

      // Missing sync at slot 0.
      word(1'b0, 8'hB1); word(1'b0, 8'hB2); word(1'b0, 8'hB3);
      check("ms_slot0", 64'(slot), 64'h0);
      saved = dout;
      word(1'b0, 8'h66);
      check("ms_se", 64'(sync_err), 64'h1);
      check("ms_cv", 64'(ch_valid), 64'h0);
      check("ms_locked", 64'(locked), 64'h0);
      check("ms_slot", 64'(slot), 64'h0);
      check("ms_dout", 64'(dout), 64'(saved));

      // Reset in the middle of a frame.
      word(1'b1, 8'hC0); word(1'b0, 8'hC1); word(1'b0, 8'hC2);
      check("rm_slot3", 64'(slot), 64'h3);
      pulse_reset();
      check("rm_dout", 64'(dout), 64'h0);
      check("rm_locked", 64'(locked), 64'h0);
      check("rm_slot", 64'(slot), 64'h0);
      word(1'b0, 8'hD0);
      check("rm_disc_cv", 64'(ch_valid), 64'h0);
      check("rm_disc_dout", 64'(dout), 64'h0);

      // Randomized stream, with occasional sync faults, gaps, disables
      // and resets.
      sent = 0;
      for (int i = 0; i < 4000; i++) begin
         bit en, v, fs;
         rst_n = ($urandom_range(0, 199) != 0);
         en    = ($urandom_range(0, 9) != 0);
         v     = ($urandom_range(0, 9) < 7);
         fs    = ((sent % NUM_CH) == 0);
         if ($urandom_range(0, 99) < 6) fs = ~fs;
         if (en && v) sent++;
         step(en, v, fs, DATA_W'($urandom));
      end
      rst_n = 1'b1;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the team's enabled 2:1 multiplexer.
- Takes one time-division-multiplexed word stream (one word per slot, slot 0 marked by frame_sync) and distributes it to NUM_CH registered output channels.
- Signals each channel update with a one-cycle strobe.
- Tracks frame alignment with a small hunt/lock state machine and flags sync errors.

Parameters:
- NUM_CH, 4, number of channels/slots per frame (2..16).
- DATA_W, 8, width of each slot word in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  high = demux active; low = stream ignored, strobes suppressed.
- din  input  DATA_W  incoming TDM word.
- din_valid  input  1  din carries a word this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current word as slot 0.
- dout  output  NUM_CH*DATA_W  channel registers; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_valid  output  NUM_CH  one-cycle strobe; bit k high when channel k was written last cycle.
- frame_done  output  1  one-cycle pulse when slot NUM_CH-1 is written.
- locked  output  1  high while in LOCK state.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- slot  output  $clog2(NUM_CH)  slot index expected for the next accepted word.

Behaviour:
- Reset (rst_n low at a clk edge):
  - dout=0, ch_valid=0, frame_done=0, sync_err=0, locked=0, slot=0.
  - State=HUNT.
  - Reset overrides everything, including mid-frame; the partial frame is discarded.
- Accepted word: enable=1 and din_valid=1 in the same cycle. Only accepted words change state, slot or dout.
- Latency: word accepted in cycle N appears in dout and its ch_valid bit in cycle N+1. Registered outputs only; no combinational input-to-output path.
- HUNT state:
  - Accepted word with frame_sync=0: discarded, no strobe.
  - Accepted word with frame_sync=1: written to channel 0, ch_valid[0] pulses, slot becomes 1 (mod NUM_CH), state goes to LOCK, locked=1 from N+1.
- LOCK state, accepted word at expected slot s:
  - frame_sync=0 and s!=0: write channel s, strobe bit s, slot=s+1. If s=NUM_CH-1, slot wraps to 0 and frame_done pulses in the same cycle as ch_valid[NUM_CH-1].
  - frame_sync=1 and s=0: normal slot-0 write, slot=1.
  - frame_sync=1 and s!=0 (early sync): sync_err pulses; word written to channel 0; slot=1; stay in LOCK. The frame is realigned with no frame_done for the truncated frame.
  - frame_sync=0 and s=0 (missing sync): sync_err pulses; word discarded; state goes to HUNT, locked=0, slot=0.
- Gaps: din_valid=0 cycles are idle. State, slot and dout hold, and strobes are 0. Gaps of any length are allowed mid-frame.
- enable=0:
  - No words accepted; state, slot and locked hold.
  - ch_valid, frame_done and sync_err are 0; dout holds (see optional feature).
  - Re-asserting enable resumes at the held slot.
- At most one ch_valid bit is high in any cycle.
- frame_done and sync_err are never high in the same cycle.

Optional Feature:
- Macro: TDM_DEMUX_CLR_ON_DISABLE_EN.
- Defined: every cycle with enable=0 and rst_n=1 clears dout to 0 at the clk edge; state, slot and locked still hold. This mirrors the forced-zero output of the enabled multiplexer.
- Not defined: dout holds its last values while enable=0.

Test Plan:
- Reset then lock (NUM_CH=4, DATA_W=8): rst_n low 2 cycles, then enable=1, four consecutive valid words 0x11(frame_sync=1), 0x22, 0x33, 0x44.
  - Expect after the last word: dout=0x44332211, ch_valid 0001,0010,0100,1000 on successive cycles, frame_done with the 1000 strobe, locked=1, slot=0, sync_err never high.
- Hunt discard: from reset, send 0xAA, 0xBB without frame_sync, then 0xCC with frame_sync.
  - Expect no strobes for the first two words, ch_valid[0] for 0xCC, dout channel 0 = 0xCC, locked=1 the following cycle.
- Gaps and disable: while locked at slot 2, hold din_valid=0 for 3 cycles, then enable=0 for 2 cycles with din_valid=1 and din=0x77, then enable=1 with din=0x55.
  - Expect 0x77 ignored, 0x55 written to channel 2.
  - Expect dout unchanged during the disable cycles without the macro, and dout=0 during them with TDM_DEMUX_CLR_ON_DISABLE_EN.
- Early sync: locked at slot 2, send 0x99 with frame_sync=1.
  - Expect sync_err pulse, ch_valid[0], channel 0 = 0x99, slot=1, locked stays 1, no frame_done.
- Missing sync: locked at slot 0, send 0x66 with frame_sync=0.
  - Expect sync_err pulse, no strobe, locked=0, slot=0, dout unchanged.
- Reset mid-frame: locked at slot 3 with nonzero dout, pulse rst_n low for one cycle.
  - Expect dout=0, locked=0, slot=0 next cycle.
  - Expect a following word without frame_sync to be discarded.
